// File: rtl/av2_sb_recon_stream_if.sv
// Stream bundle for the SB reconstruction engine: prediction and residual inputs, pixel output.
// Handshake: a beat transfers on a rising edge where valid and ready are both high; the source holds valid and data stable until then.
interface av2_sb_recon_stream_if #(
  parameter int PIXEL_WIDTH = 10,
  parameter int RES_WIDTH   = 16,
  parameter int LANES       = 16,
  parameter int ADDR_WIDTH  = 32
);
  logic [LANES*PIXEL_WIDTH-1:0] pred_data;
  logic                         pred_valid;
  logic                         pred_ready;
  logic [LANES*RES_WIDTH-1:0]   res_data;
  logic                         res_valid;
  logic                         res_ready;
  logic [LANES*PIXEL_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0]        out_addr;
  logic [LANES-1:0]             out_mask;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output pred_data, pred_valid, res_data, res_valid, out_ready,
    input  pred_ready, res_ready, out_data, out_addr, out_mask, out_valid
  );

  modport slave (
    input  pred_data, pred_valid, res_data, res_valid, out_ready,
    output pred_ready, res_ready, out_data, out_addr, out_mask, out_valid
  );
endinterface

// File: rtl/av2_sb_recon_stream.sv
// Streaming reconstruction: walks a frame in superblock raster order, adds residual to prediction
// with clipping, and emits packed pixel beats carrying a frame-linear address and a lane mask.
module av2_sb_recon_stream #(
  parameter int PIXEL_WIDTH = 10,
  parameter int RES_WIDTH   = 16,
  parameter int LANES       = 16,
  parameter int SB_SIZE     = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] frame_width,
  input  logic [15:0] frame_height,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fsm_state,
  av2_sb_recon_stream_if.slave bus
);
  localparam int PW = PIXEL_WIDTH;
  localparam int SW = RES_WIDTH + 2;
  localparam int CW = $clog2(SB_SIZE);
  localparam logic [16:0]   SB17 = 17'(SB_SIZE);
  localparam logic [16:0]   LN17 = 17'(LANES);
  localparam logic [PW-1:0] PMAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t state_q, state_d;
  logic   fire;
  logic   last_col, last_row, last_sbx, last_sby, last_beat;

  logic [15:0]           fw_q, fh_q;
  logic [16:0]           x0_q, y0_q;
  logic [CW-1:0]         col_q, row_q;
  logic [16:0]           col17, row17, rem_w, rem_h, eff_w, eff_h;
  logic [ADDR_WIDTH-1:0] row_base_q, sb_base_q, fw_aw, fw_sb, beat_addr;

  logic [LANES*PW-1:0] lane_data;
  logic [LANES-1:0]    lane_mask;

  function automatic logic [PW-1:0] recon_px(input logic [PW-1:0] p,
                                             input logic [RES_WIDTH-1:0] r);
    logic signed [SW-1:0] sum;
    sum = $signed({{(SW-PW){1'b0}}, p}) + $signed({{2{r[RES_WIDTH-1]}}, r});
    if (sum[SW-1])
      recon_px = '0;
    else if (sum > $signed({{(SW-PW){1'b0}}, PMAX}))
      recon_px = PMAX;
    else
      recon_px = sum[PW-1:0];
  endfunction

  // Effective SB extent clips at the right/bottom frame edge.
  assign col17 = 17'(col_q);
  assign row17 = 17'(row_q);
  assign rem_w = {1'b0, fw_q} - x0_q;
  assign rem_h = {1'b0, fh_q} - y0_q;
  assign eff_w = (rem_w > SB17) ? SB17 : rem_w;
  assign eff_h = (rem_h > SB17) ? SB17 : rem_h;

  assign last_col  = (col17 + LN17) >= eff_w;
  assign last_row  = (row17 + 17'd1) >= eff_h;
  assign last_sbx  = (x0_q + SB17) >= {1'b0, fw_q};
  assign last_sby  = (y0_q + SB17) >= {1'b0, fh_q};
  assign last_beat = last_col & last_row & last_sbx & last_sby;

  // row_base tracks (y0+row)*fw and sb_base tracks y0*fw so no multiplier is needed.
  assign fw_aw     = ADDR_WIDTH'(fw_q);
  assign fw_sb     = fw_aw << CW;
  assign beat_addr = row_base_q + ADDR_WIDTH'(x0_q) + ADDR_WIDTH'(col_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (frame_width == 16'd0 || frame_height == 16'd0) ? DONE : RUN;
      RUN:   if (fire && last_beat) state_d = DRAIN;
      DRAIN: if (!bus.out_valid || bus.out_ready) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    fire = 1'b0;
    unique case (state_q)
      RUN: begin
        busy = 1'b1;
        fire = bus.pred_valid & bus.res_valid & (~bus.out_valid | bus.out_ready);
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign fsm_state      = state_q;
  assign bus.pred_ready = fire;
  assign bus.res_ready  = fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_q       <= '0;
      fh_q       <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      sb_base_q  <= '0;
    end else if (state_q == IDLE && start) begin
      fw_q       <= frame_width;
      fh_q       <= frame_height;
      x0_q       <= '0;
      y0_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      sb_base_q  <= '0;
    end else if (fire) begin
      if (!last_col) begin
        col_q <= col_q + CW'(LANES);
      end else begin
        col_q <= '0;
        if (!last_row) begin
          row_q      <= row_q + 1'b1;
          row_base_q <= row_base_q + fw_aw;
        end else begin
          row_q <= '0;
          if (!last_sbx) begin
            x0_q       <= x0_q + SB17;
            row_base_q <= sb_base_q;
          end else begin
            x0_q       <= '0;
            y0_q       <= y0_q + SB17;
            sb_base_q  <= sb_base_q + fw_sb;
            row_base_q <= sb_base_q + fw_sb;
          end
        end
      end
    end
  end

  always_comb begin
    lane_data = '0;
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((col17 + 17'(i)) < eff_w) begin
        lane_mask[i]          = 1'b1;
        lane_data[i*PW +: PW] = recon_px(bus.pred_data[i*PW +: PW],
                                         bus.res_data[i*RES_WIDTH +: RES_WIDTH]);
      end
    end
  end

  // Output slot: loads on fire, empties on a handshake with no replacement beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.out_mask  <= '0;
    end else if (fire) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= lane_data;
      bus.out_addr  <= beat_addr;
      bus.out_mask  <= lane_mask;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_av2_sb_recon_stream.sv
// Directed bench for av2_sb_recon_stream: full frames, clipping, partial SBs, backpressure,
// zero-size frames, ignored restarts and reset mid-frame.
`timescale 1ns/1ps
module tb_av2_sb_recon_stream;
  localparam int PW = 10;
  localparam int RW = 16;
  localparam int LN = 16;
  localparam int SB = 64;
  localparam int AW = 32;
  localparam int DW = LN*PW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] frame_width = '0;
  logic [15:0] frame_height = '0;
  logic        busy, done;
  logic [1:0]  fsm_state;

  av2_sb_recon_stream_if #(.PIXEL_WIDTH(PW), .RES_WIDTH(RW), .LANES(LN), .ADDR_WIDTH(AW)) bus ();

  av2_sb_recon_stream #(.PIXEL_WIDTH(PW), .RES_WIDTH(RW), .LANES(LN), .SB_SIZE(SB),
                        .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_width(frame_width),
    .frame_height(frame_height), .busy(busy), .done(done), .fsm_state(fsm_state), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] got_addr_q[$];
  logic [LN-1:0] got_mask_q[$];
  logic [DW-1:0] got_data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [LN-1:0] exp_mask_q[$];

  int  first_hs_edge, last_hs_edge, done_edge, start_edge;
  int  stable_err, pair_err, bad_idx;
  bit  busy_seen, timed_out, prev_stall;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;
  logic [LN-1:0] prev_mask;

  int mode, pred_base, res_base;
  int t_pred[LN];
  int t_res[LN];

  // Monitor: records every output handshake and watches stall stability and ready pairing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) busy_seen = 1'b1;
      if (bus.pred_ready !== bus.res_ready) pair_err++;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                         bus.out_addr !== prev_addr || bus.out_mask !== prev_mask))
        stable_err++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (got_addr_q.size() == 0) first_hs_edge = cyc + 1;
        last_hs_edge = cyc + 1;
        got_addr_q.push_back(bus.out_addr);
        got_mask_q.push_back(bus.out_mask);
        got_data_q.push_back(bus.out_data);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_addr  = bus.out_addr;
      prev_mask  = bus.out_mask;
    end
  end

  function automatic int pred_lane(int k, int i);
    case (mode)
      0:       return pred_base;
      1:       return (k*3 + i*37) % 1024;
      default: return t_pred[i];
    endcase
  endfunction

  function automatic int res_lane(int k, int i);
    case (mode)
      0:       return res_base;
      1:       return ((k*5 + i*11) % 101) - 50;
      default: return t_res[i];
    endcase
  endfunction

  function automatic int clip_px(int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  function automatic logic [DW-1:0] pack_pred(int k);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < LN; i++) v[i*PW +: PW] = PW'(pred_lane(k, i));
    return v;
  endfunction

  function automatic logic [LN*RW-1:0] pack_res(int k);
    logic [LN*RW-1:0] v;
    v = '0;
    for (int i = 0; i < LN; i++) v[i*RW +: RW] = RW'(res_lane(k, i));
    return v;
  endfunction

  task automatic build_exp(input int fw, input int fh);
    int h, w;
    logic [LN-1:0] m;
    exp_addr_q.delete();
    exp_mask_q.delete();
    for (int sy = 0; sy*SB < fh; sy++) begin
      h = (fh - sy*SB < SB) ? fh - sy*SB : SB;
      for (int sx = 0; sx*SB < fw; sx++) begin
        w = (fw - sx*SB < SB) ? fw - sx*SB : SB;
        for (int r = 0; r < h; r++)
          for (int c = 0; c < w; c += LN) begin
            m = '0;
            for (int i = 0; i < LN; i++) if (c + i < w) m[i] = 1'b1;
            exp_addr_q.push_back(AW'((sy*SB + r)*fw + sx*SB + c));
            exp_mask_q.push_back(m);
          end
      end
    end
  endtask

  function automatic int stream_errs();
    int errs;
    logic [DW-1:0] ed;
    errs = 0;
    bad_idx = -1;
    if (got_addr_q.size() != exp_addr_q.size()) errs++;
    for (int k = 0; k < got_addr_q.size() && k < exp_addr_q.size(); k++) begin
      ed = '0;
      for (int i = 0; i < LN; i++)
        if (exp_mask_q[k][i]) ed[i*PW +: PW] = PW'(clip_px(pred_lane(k, i) + res_lane(k, i)));
      if (got_addr_q[k] !== exp_addr_q[k] || got_mask_q[k] !== exp_mask_q[k] || got_data_q[k] !== ed) begin
        if (bad_idx < 0) bad_idx = k;
        errs++;
      end
    end
    return errs;
  endfunction

  // Runs one frame: start pulse, stream driving, waits for done within a cycle budget.
  task automatic run_frame(input int fw, input int fh, input bit rnd, input int abort_at,
                           input bit restart_mid);
    int  pred_idx, res_idx;
    bit  p_fire, r_fire;
    got_addr_q.delete();
    got_mask_q.delete();
    got_data_q.delete();
    stable_err = 0; pair_err = 0; busy_seen = 1'b0;
    done_edge = -1; first_hs_edge = -1; last_hs_edge = -1;
    pred_idx = 0; res_idx = 0; p_fire = 1'b0; r_fire = 1'b0;
    timed_out = 1'b1;
    @(posedge clk); #1;
    frame_width  = 16'(fw);
    frame_height = 16'(fh);
    start        = 1'b1;
    start_edge   = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (rnd) begin
        if (!bus.pred_valid || p_fire) bus.pred_valid = 1'($urandom_range(0, 1));
        if (!bus.res_valid || r_fire)  bus.res_valid  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.pred_valid = 1'b1;
        bus.res_valid  = 1'b1;
        bus.out_ready  = 1'b1;
      end
      bus.pred_data = pack_pred(pred_idx);
      bus.res_data  = pack_res(res_idx);
      @(negedge clk);
      p_fire = bus.pred_valid && bus.pred_ready;
      r_fire = bus.res_valid && bus.res_ready;
      if (done === 1'b1) begin
        done_edge = cyc;
        timed_out = 1'b0;
        break;
      end
      if (abort_at > 0 && got_addr_q.size() >= abort_at) begin
        rst_n = 1'b0;
        timed_out = 1'b0;
        break;
      end
      if (restart_mid && c == 20) begin
        frame_width = 16'd64; frame_height = 16'd64; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (p_fire) pred_idx++;
      if (r_fire) res_idx++;
    end
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
    bus.out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({busy, done, bus.pred_ready, bus.res_ready, bus.out_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, bus.pred_ready, bus.res_ready, bus.out_valid});
    end
    n_tests++;
    if (bus.out_data !== '0 || bus.out_addr !== '0 || bus.out_mask !== '0) begin
      n_fail++; $display("FAIL reset_data: got data %h addr %0d mask %h expected all 0", bus.out_data, bus.out_addr, bus.out_mask);
    end
    n_tests++;
    if (fsm_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", fsm_state);
    end
  endtask

  task automatic test_full_frame();
    logic [DW-1:0] all138;
    for (int i = 0; i < LN; i++) all138[i*PW +: PW] = 10'd138;
    mode = 0; pred_base = 128; res_base = 10;
    build_exp(64, 64);
    run_frame(64, 64, 1'b0, 0, 1'b0);
    n_tests++;
    if (timed_out !== 1'b0) begin n_fail++; $display("FAIL t1_timeout: got %0d expected 0", timed_out); end
    n_tests++;
    if (got_addr_q.size() != 256) begin n_fail++; $display("FAIL t1_beats: got %0d expected 256", got_addr_q.size()); end
    n_tests++;
    if (stream_errs() != 0) begin n_fail++; $display("FAIL t1_stream: got %0d bad beats (first %0d) expected 0", stream_errs(), bad_idx); end
    n_tests++;
    if (got_data_q.size() < 1 || got_data_q[0] !== all138 || got_mask_q[0] !== 16'hFFFF) begin
      n_fail++; $display("FAIL t1_first_beat: got data %h expected %h", got_data_q.size() > 0 ? got_data_q[0] : '0, all138);
    end
    n_tests++;
    if (got_addr_q.size() < 5 || got_addr_q[1] !== 32'd16 || got_addr_q[4] !== 32'd64) begin
      n_fail++; $display("FAIL t1_addr: got beat4 addr %0d expected 64", got_addr_q.size() > 4 ? got_addr_q[4] : 0);
    end
    n_tests++;
    if (done_edge != last_hs_edge) begin n_fail++; $display("FAIL t1_done_timing: got edge %0d expected %0d", done_edge, last_hs_edge); end
    n_tests++;
    if (last_hs_edge - first_hs_edge != 255) begin
      n_fail++; $display("FAIL t1_back_to_back: got span %0d expected 255", last_hs_edge - first_hs_edge);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_at_done: got %b expected 0", busy); end
  endtask

  task automatic test_clip();
    int exp_px[8] = '{1023, 0, 0, 1023, 497, 1023, 1023, 0};
    int px;
    for (int i = 0; i < LN; i++) begin t_pred[i] = 0; t_res[i] = 0; end
    t_pred[0] = 1020; t_res[0] = 50;
    t_pred[1] = 5;    t_res[1] = -50;
    t_pred[2] = 0;    t_res[2] = -32768;
    t_pred[3] = 1023; t_res[3] = 32767;
    t_pred[4] = 500;  t_res[4] = -3;
    t_pred[5] = 0;    t_res[5] = 1023;
    t_pred[6] = 1023; t_res[6] = 0;
    t_pred[7] = 1;    t_res[7] = -1;
    mode = 2;
    build_exp(16, 1);
    run_frame(16, 1, 1'b0, 0, 1'b0);
    n_tests++;
    if (timed_out !== 1'b0 || got_data_q.size() != 1) begin
      n_fail++; $display("FAIL t2_beats: got %0d beats expected 1", got_data_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        px = int'(got_data_q[0][i*PW +: PW]);
        n_tests++;
        if (px != exp_px[i]) begin n_fail++; $display("FAIL t2_lane%0d: got %0d expected %0d", i, px, exp_px[i]); end
      end
    end
  endtask

  task automatic test_partial_sb();
    mode = 1;
    build_exp(72, 40);
    run_frame(72, 40, 1'b0, 0, 1'b0);
    n_tests++;
    if (timed_out !== 1'b0 || got_addr_q.size() != 200) begin
      n_fail++; $display("FAIL t3_beats: got %0d expected 200", got_addr_q.size());
    end
    n_tests++;
    if (stream_errs() != 0) begin n_fail++; $display("FAIL t3_stream: got %0d bad beats (first %0d) expected 0", stream_errs(), bad_idx); end
    n_tests++;
    if (got_addr_q.size() < 162 || got_addr_q[159] !== 32'd2856 || got_addr_q[160] !== 32'd64 ||
        got_addr_q[161] !== 32'd136) begin
      n_fail++; $display("FAIL t3_addr: got beat160 addr %0d expected 64", got_addr_q.size() > 160 ? got_addr_q[160] : 0);
    end
    n_tests++;
    if (got_mask_q.size() < 161 || got_mask_q[160] !== 16'h00FF || got_data_q[160][DW-1:80] !== '0) begin
      n_fail++; $display("FAIL t3_mask: got mask %h expected 00ff with upper lanes 0", got_mask_q.size() > 160 ? got_mask_q[160] : '0);
    end
  endtask

  task automatic test_backpressure();
    mode = 1;
    build_exp(64, 64);
    run_frame(64, 64, 1'b1, 0, 1'b0);
    n_tests++;
    if (timed_out !== 1'b0 || got_addr_q.size() != 256) begin
      n_fail++; $display("FAIL t4_beats: got %0d expected 256", got_addr_q.size());
    end
    n_tests++;
    if (stream_errs() != 0) begin n_fail++; $display("FAIL t4_stream: got %0d bad beats (first %0d) expected 0", stream_errs(), bad_idx); end
    n_tests++;
    if (stable_err != 0) begin n_fail++; $display("FAIL t4_stall_stable: got %0d changes expected 0", stable_err); end
    n_tests++;
    if (pair_err != 0) begin n_fail++; $display("FAIL t4_ready_pair: got %0d splits expected 0", pair_err); end
  endtask

  task automatic test_zero_and_restart();
    mode = 1;
    build_exp(0, 16);
    run_frame(0, 16, 1'b0, 0, 1'b0);
    n_tests++;
    if (timed_out !== 1'b0 || done_edge != start_edge) begin
      n_fail++; $display("FAIL t5_zero_done: got edge %0d expected %0d", done_edge, start_edge);
    end
    n_tests++;
    if (got_addr_q.size() != 0 || busy_seen) begin
      n_fail++; $display("FAIL t5_zero_beats: got %0d beats busy %b expected 0 beats busy 0", got_addr_q.size(), busy_seen);
    end
    build_exp(32, 16);
    run_frame(32, 16, 1'b0, 0, 1'b1);
    n_tests++;
    if (timed_out !== 1'b0 || got_addr_q.size() != 32) begin
      n_fail++; $display("FAIL t5_restart_beats: got %0d expected 32", got_addr_q.size());
    end
    n_tests++;
    if (stream_errs() != 0) begin n_fail++; $display("FAIL t5_restart_stream: got %0d bad beats expected 0", stream_errs()); end
  endtask

  task automatic test_reset_mid_frame();
    mode = 0; pred_base = 128; res_base = 10;
    build_exp(64, 64);
    run_frame(64, 64, 1'b0, 100, 1'b0);
    #1;
    n_tests++;
    if ({busy, done, bus.pred_ready, bus.out_valid} !== 4'b0 || bus.out_data !== '0 ||
        bus.out_addr !== '0 || bus.out_mask !== '0) begin
      n_fail++; $display("FAIL t6_reset_outputs: got valid %b addr %0d mask %h expected all 0", bus.out_valid, bus.out_addr, bus.out_mask);
    end
    n_tests++;
    if (done_edge != -1 || got_addr_q.size() < 100) begin
      n_fail++; $display("FAIL t6_abort: got done edge %0d beats %0d expected -1 and >=100", done_edge, got_addr_q.size());
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_frame(64, 64, 1'b0, 0, 1'b0);
    n_tests++;
    if (timed_out !== 1'b0 || got_addr_q.size() != 256 || got_addr_q[0] !== 32'd0) begin
      n_fail++; $display("FAIL t6_rerun_beats: got %0d expected 256 from addr 0", got_addr_q.size());
    end
    n_tests++;
    if (stream_errs() != 0) begin n_fail++; $display("FAIL t6_rerun_stream: got %0d bad beats expected 0", stream_errs()); end
  endtask

  initial begin
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
    bus.out_ready  = 1'b1;
    bus.pred_data  = '0;
    bus.res_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    test_full_frame();
    test_clip();
    test_partial_sb();
    test_backpressure();
    test_zero_and_restart();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
